// File: rtl/upsample2d_stream_if.sv
// Valid/ready pixel stream used on both sides of the upsampler.
// One beat carries one pixel with all channels packed.
interface upsample2d_stream_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/upsample2d_stream.sv
// Streaming 2-D upsampler: each input row lands in one of two line banks and is
// replayed SCALE times at SCALE-fold horizontal expansion (replicate or zero-insert).
module upsample2d_stream #(
  parameter int    CH    = 1,
  parameter int    IN_H  = 1,
  parameter int    IN_W  = 1,
  parameter int    SCALE = 2,
  parameter int    WIDTH = 16,
  parameter string MODE  = "NEAREST"
) (
  input  logic                clk,
  input  logic                rst,
  upsample2d_stream_if.slave  in_i,
  upsample2d_stream_if.master out_o,
  output logic                out_last_o
);

  localparam int DW = CH * WIDTH;
  localparam int CW = (IN_W  > 1) ? $clog2(IN_W)  : 1;
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int HW = (IN_H  > 1) ? $clog2(IN_H)  : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [HW-1:0] IR_LAST  = HW'(IN_H - 1);
  localparam bit ZERO_MODE = (MODE == "ZERO");

  logic [DW-1:0] bank_q [2][IN_W];
  logic [1:0]    full_q,   full_d;
  logic          wr_sel_q, wr_sel_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic          rd_sel_q, rd_sel_d;
  // Output column ow is tracked as (rd_col, rd_sub) = (ow / SCALE, ow % SCALE).
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [SW-1:0] rd_sub_q, rd_sub_d;
  logic [SW-1:0] rep_q,    rep_d;
  logic [HW-1:0] ir_q,     ir_d;

  logic          in_acc_s;
  logic          out_vld_s;
  logic          out_acc_s;
  logic [DW-1:0] pix_s;
  logic [DW-1:0] out_data_s;

  assign in_acc_s  = in_i.valid && !full_q[wr_sel_q];
  assign out_vld_s = full_q[rd_sel_q];
  assign out_acc_s = out_vld_s && out_o.ready;
  assign pix_s     = bank_q[rd_sel_q][rd_col_q];

  // Writer and reader counter next-state; the two sides only ever touch different full flags.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    wr_col_d = wr_col_q;
    rd_sel_d = rd_sel_q;
    rd_col_d = rd_col_q;
    rd_sub_d = rd_sub_q;
    rep_d    = rep_q;
    ir_d     = ir_q;
    if (in_acc_s) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_d         = '0;
        wr_sel_d         = ~wr_sel_q;
        full_d[wr_sel_q] = 1'b1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end else begin
      wr_col_d = wr_col_q;
    end
    if (out_acc_s) begin
      if (rd_sub_q == SUB_LAST) begin
        rd_sub_d = '0;
        if (rd_col_q == COL_LAST) begin
          rd_col_d = '0;
          if (rep_q == SUB_LAST) begin
            rep_d            = '0;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            ir_d             = (ir_q == IR_LAST) ? '0 : ir_q + 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end else begin
        rd_sub_d = rd_sub_q + 1'b1;
      end
    end else begin
      rd_sub_d = rd_sub_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      wr_col_q <= '0;
      rd_sel_q <= 1'b0;
      rd_col_q <= '0;
      rd_sub_q <= '0;
      rep_q    <= '0;
      ir_q     <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      wr_col_q <= wr_col_d;
      rd_sel_q <= rd_sel_d;
      rd_col_q <= rd_col_d;
      rd_sub_q <= rd_sub_d;
      rep_q    <= rep_d;
      ir_q     <= ir_d;
    end
  end

  // Line bank storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < IN_W; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (in_acc_s) begin
      bank_q[wr_sel_q][wr_col_q] <= in_i.data;
    end else begin
      bank_q[wr_sel_q][wr_col_q] <= bank_q[wr_sel_q][wr_col_q];
    end
  end

  // Output pixel select; zero-insert keeps only the top-left sample of each SCALE x SCALE tile.
  always_comb begin
    out_data_s = '0;
    if (!out_vld_s) begin
      out_data_s = '0;
    end else if (ZERO_MODE && ((rep_q != '0) || (rd_sub_q != '0))) begin
      out_data_s = '0;
    end else begin
      out_data_s = pix_s;
    end
  end

  assign in_i.ready  = !full_q[wr_sel_q];
  assign out_o.valid = out_vld_s;
  assign out_o.data  = out_data_s;
  assign out_last_o  = out_vld_s && (ir_q == IR_LAST) && (rep_q == SUB_LAST) &&
                       (rd_col_q == COL_LAST) && (rd_sub_q == SUB_LAST);

endmodule

// File: tb/tb_upsample2d_stream.sv
// Self-checking bench for upsample2d_stream: four configurations, randomized handshakes,
// expected streams computed from the upsampling rule over whole frames.
module tb_upsample2d_stream;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data [4];
  logic          in_valid [4];
  logic          out_ready [4];
  logic          in_ready_w [4];
  logic          out_valid_w [4];
  logic [DW-1:0] out_data_w [4];
  logic          out_last_w [4];

  upsample2d_stream_if #(.DW(DW)) in_if0 (), out_if0 (), in_if1 (), out_if1 ();
  upsample2d_stream_if #(.DW(DW)) in_if2 (), out_if2 (), in_if3 (), out_if3 ();

  assign in_if0.data = in_data[0]; assign in_if0.valid = in_valid[0]; assign in_ready_w[0] = in_if0.ready;
  assign in_if1.data = in_data[1]; assign in_if1.valid = in_valid[1]; assign in_ready_w[1] = in_if1.ready;
  assign in_if2.data = in_data[2]; assign in_if2.valid = in_valid[2]; assign in_ready_w[2] = in_if2.ready;
  assign in_if3.data = in_data[3]; assign in_if3.valid = in_valid[3]; assign in_ready_w[3] = in_if3.ready;
  assign out_if0.ready = out_ready[0]; assign out_valid_w[0] = out_if0.valid; assign out_data_w[0] = out_if0.data;
  assign out_if1.ready = out_ready[1]; assign out_valid_w[1] = out_if1.valid; assign out_data_w[1] = out_if1.data;
  assign out_if2.ready = out_ready[2]; assign out_valid_w[2] = out_if2.valid; assign out_data_w[2] = out_if2.data;
  assign out_if3.ready = out_ready[3]; assign out_valid_w[3] = out_if3.valid; assign out_data_w[3] = out_if3.data;

  upsample2d_stream #(.CH(1), .IN_H(2), .IN_W(2), .SCALE(2), .WIDTH(16), .MODE("NEAREST")) dut_n (
    .clk(clk), .rst(rst), .in_i(in_if0), .out_o(out_if0), .out_last_o(out_last_w[0]));
  upsample2d_stream #(.CH(1), .IN_H(2), .IN_W(2), .SCALE(2), .WIDTH(16), .MODE("ZERO")) dut_z (
    .clk(clk), .rst(rst), .in_i(in_if1), .out_o(out_if1), .out_last_o(out_last_w[1]));
  upsample2d_stream #(.CH(2), .IN_H(3), .IN_W(3), .SCALE(3), .WIDTH(8), .MODE("NEAREST")) dut_r (
    .clk(clk), .rst(rst), .in_i(in_if2), .out_o(out_if2), .out_last_o(out_last_w[2]));
  upsample2d_stream #(.CH(1), .IN_H(1), .IN_W(4), .SCALE(1), .WIDTH(16), .MODE("NEAREST")) dut_p (
    .clk(clk), .rst(rst), .in_i(in_if3), .out_o(out_if3), .out_last_o(out_last_w[3]));

  int checks;
  int errors;
  logic [DW-1:0] in_q [$];
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];
  logic [DW-1:0] obs_d [$];
  logic          obs_l [$];
  int            in_acc_cyc [$];
  int            first_vld;

  // Reference: every output pixel (oh, ow) comes from input (oh/s, ow/s), frame after frame.
  task automatic build_exp(input int h, input int w, input int s, input bit zero, input int frames);
    logic [DW-1:0] p;
    exp_d.delete();
    exp_l.delete();
    for (int f = 0; f < frames; f++) begin
      for (int oh = 0; oh < h * s; oh++) begin
        for (int ow = 0; ow < w * s; ow++) begin
          p = in_q[f * h * w + (oh / s) * w + ow / s];
          if (zero && ((oh % s) != 0 || (ow % s) != 0)) p = '0;
          exp_d.push_back(p);
          exp_l.push_back((oh == h * s - 1) && (ow == w * s - 1));
        end
      end
    end
  endtask

  task automatic run_stream(input int k, input int n_in, input int n_out, input int in_pct,
                            input int out_pct, input int max_cyc);
    int acc_in = 0;
    int cyc = 0;
    bit pend = 1'b0;
    bit hold = 1'b0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    first_vld = -1;
    in_acc_cyc.delete();
    obs_d.delete();
    obs_l.delete();
    while ((acc_in < n_in || obs_d.size() < n_out) && cyc < max_cyc) begin
      @(negedge clk);
      if (acc_in < n_in) begin
        if (!pend) begin
          in_valid[k] = ($urandom_range(99) < in_pct);
          in_data[k]  = in_q[acc_in];
        end
      end else begin
        in_valid[k] = 1'b0;
        in_data[k]  = '0;
      end
      out_ready[k] = (obs_d.size() < n_out) && ($urandom_range(99) < out_pct);
      #1;
      if (hold) begin
        checks++;
        if (out_valid_w[k] !== 1'b1 || out_data_w[k] !== pd || out_last_w[k] !== pl) begin
          errors++;
          $display("FAIL hold_k%0d: got valid=%0b data=%0h last=%0b, expected valid=1 data=%0h last=%0b",
                   k, out_valid_w[k], out_data_w[k], out_last_w[k], pd, pl);
        end
      end
      if (out_valid_w[k] && first_vld < 0) first_vld = cyc;
      pend = in_valid[k] && !in_ready_w[k];
      if (in_valid[k] && in_ready_w[k]) begin
        in_acc_cyc.push_back(cyc);
        acc_in++;
      end
      if (out_valid_w[k] && out_ready[k]) begin
        obs_d.push_back(out_data_w[k]);
        obs_l.push_back(out_last_w[k]);
      end
      hold = out_valid_w[k] && !out_ready[k];
      pd   = out_data_w[k];
      pl   = out_last_w[k];
      cyc++;
    end
    checks++;
    if (acc_in < n_in || obs_d.size() < n_out) begin
      errors++;
      $display("FAIL timeout_k%0d: got %0d in / %0d out, expected %0d in / %0d out",
               k, acc_in, obs_d.size(), n_in, n_out);
    end
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready_w[k] !== 1'b1 || out_valid_w[k] !== 1'b0 || out_data_w[k] !== '0 || out_last_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_k%0d: got rdy=%0b vld=%0b data=%0h last=%0b, expected 1 0 0 0",
                 k, in_ready_w[k], out_valid_w[k], out_data_w[k], out_last_w[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_nearest();
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_stream(0, 4, 16, 100, 100, 200);
    build_exp(2, 2, 2, 1'b0, 1);
    checks++;
    if (obs_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL nearest_count: got %0d, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL nearest_beat%0d: got %0h/%0b, expected %0h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (in_acc_cyc.size() < 2 || first_vld != in_acc_cyc[1] + 1) begin
      errors++;
      $display("FAIL latency: got first valid at cycle %0d, expected one cycle after row end", first_vld);
    end
  endtask

  task automatic test_zero();
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_stream(1, 4, 16, 100, 100, 200);
    build_exp(2, 2, 2, 1'b1, 1);
    checks++;
    if (obs_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL zero_count: got %0d, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL zero_beat%0d: got %0h/%0b, expected %0h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_stream(0, 4, 0, 100, 0, 100);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0063;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b1 || out_data_w[0] !== 16'd1) begin
        errors++;
        $display("FAIL backpressure_c%0d: got rdy=%0b vld=%0b data=%0h, expected 0 1 1",
                 c, in_ready_w[0], out_valid_w[0], out_data_w[0]);
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    run_stream(0, 0, 16, 100, 100, 200);
    build_exp(2, 2, 2, 1'b0, 1);
    checks++;
    if (obs_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %0h/%0b, expected %0h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    int lasts = 0;
    in_q.delete();
    for (int i = 0; i < 18; i++) in_q.push_back(DW'($urandom_range(65535)));
    run_stream(2, 18, 162, 60, 50, 4000);
    build_exp(3, 3, 3, 1'b0, 2);
    checks++;
    if (obs_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL random_count: got %0d, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i][7:0] !== exp_d[i][7:0] || obs_d[i][15:8] !== exp_d[i][15:8] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL random_beat%0d: got %0h/%0b, expected %0h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
      if (obs_l[i]) lasts++;
    end
    checks++;
    if (lasts != 2) begin
      errors++;
      $display("FAIL random_last_count: got %0d, expected 2", lasts);
    end
  endtask

  task automatic test_reset_mid_frame();
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_stream(0, 3, 5, 100, 100, 100);
    build_exp(2, 2, 2, 1'b0, 1);
    for (int i = 0; i < 5 && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL pre_reset_beat%0d: got %0h, expected %0h", i, obs_d[i], exp_d[i]);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || out_data_w[0] !== '0 || out_last_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got rdy=%0b vld=%0b data=%0h last=%0b, expected 1 0 0 0",
               in_ready_w[0], out_valid_w[0], out_data_w[0], out_last_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    in_q = '{16'd5, 16'd6, 16'd7, 16'd8};
    run_stream(0, 4, 16, 100, 100, 200);
    build_exp(2, 2, 2, 1'b0, 1);
    checks++;
    if (obs_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL post_reset_count: got %0d, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL post_reset_beat%0d: got %0h/%0b, expected %0h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_passthrough();
    in_q = '{16'd9, 16'd8, 16'd7, 16'd6};
    run_stream(3, 4, 4, 100, 100, 100);
    build_exp(1, 4, 1, 1'b0, 1);
    checks++;
    if (obs_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL pass_count: got %0d, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL pass_beat%0d: got %0h/%0b, expected %0h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = '0;
    end
    test_reset();
    test_nearest();
    test_zero();
    test_backpressure();
    test_random_back_to_back();
    test_reset_mid_frame();
    test_passthrough();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/upsample2d_stream.md
# upsample2d_stream

Streaming nearest-neighbour / zero-insert 2-D upsampler for decoder and FPN paths, replacing whole-tensor flat-vector upsampling where the tensor no longer fits in a single port. Pixels arrive in raster order, one pixel (all channels packed) per beat, over a valid/ready interface. Each input row is captured in a ping-pong line buffer and replayed SCALE times at SCALE× horizontal expansion, so the next row loads while the current one is emitted. Sits between a conv stage output stream and the next conv stage input stream.

## Interface
- CH, 1, channels packed per pixel beat
- IN_H, 1, input rows per frame
- IN_W, 1, input pixels per row
- SCALE, 2, integer upsample factor (≥1), both axes
- WIDTH, 16, bits per channel element
- MODE, "NEAREST", "NEAREST" = replicate; "ZERO" = zero-insert (transposed-conv style)
- precision, "Q8.8", numeric format tag; no arithmetic performed, data passed bit-exact

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  CH*WIDTH  input pixel; channel c at [c*WIDTH +: WIDTH]
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- out_data  out  CH*WIDTH  output pixel, same packing
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- out_last  out  1  high on final beat of output frame (oh=OUT_H-1, ow=OUT_W-1)

OUT_H = IN_H*SCALE, OUT_W = IN_W*SCALE.

## Operation
- Two line banks, each IN_W × CH*WIDTH registers, plus per-bank full flag.
- Writer: wr_sel, wr_col. Beat accepted when in_valid && in_ready; stores at bank[wr_sel][wr_col], wr_col++. On wr_col = IN_W-1 accept: full[wr_sel]←1, wr_col←0, wr_sel toggles. in_ready = !full[wr_sel].
- Reader: rd_sel, rep_row (0..SCALE-1), ow (0..OUT_W-1), in-row counter ir (0..IN_H-1). out_valid = full[rd_sel].
- NEAREST: out_data = bank[rd_sel][ow/SCALE].
- ZERO: out_data = bank[rd_sel][ow/SCALE] when rep_row=0 and ow%SCALE=0, else all zeros.
- out_data = 0 whenever out_valid = 0.
- On out accept: ow++; at ow=OUT_W-1 wrap to 0, rep_row++; at rep_row=SCALE-1 with ow wrap: full[rd_sel]←0, rd_sel toggles, rep_row←0, ir++ (wrap to 0 at IN_H-1; frame ends).
- out_last = out_valid && ir=IN_H-1 && rep_row=SCALE-1 && ow=OUT_W-1.
- Writer sets flag on bank wr_sel, reader clears flag on bank rd_sel in same cycle: legal, always distinct banks; both updates take effect.
- Frames back-to-back with no gap; writer may load row 0 of next frame while reader emits last row of current frame.
- SCALE=1: pass-through with one-row buffering.

## Timing
- Reset: in_ready=1, out_valid=0, out_data=0, out_last=0, all counters/selects 0, both full flags 0, bank contents 0.
- Reset mid-frame: all partial state discarded immediately; first beat after deassertion is row 0 col 0 of a new frame.
- Latency: last pixel of a row accepted at edge t → out_valid high in cycle after t (first output beat presented one cycle after row completion).
- Output holds out_data/out_last stable while out_valid && !out_ready.
- Sustained throughput: one output beat/cycle with out_ready=1; input stalls (in_ready=0) when both banks full.
- in_ready does not depend combinationally on out_ready (flag-registered); out_valid does not depend on in_valid.

## Test plan
- NEAREST, CH=1, IN_H=IN_W=2, SCALE=2: inputs 1,2,3,4, out_ready=1 -> outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; out_last only on 16th beat; first out_valid one cycle after 2nd input accepted.
- ZERO, same setup -> 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0; out_last on 16th.
- Backpressure: out_ready=0 throughout, in_valid=1 streaming 1,2,3,4 -> in_ready drops after 4th accept (both banks full); out_data=1 held; release out_ready -> stream completes correctly, no lost/duplicated beats.
- Random out_ready/in_valid toggling, CH=2, IN_H=3, IN_W=3, SCALE=3, WIDTH=8, two back-to-back frames -> 162 beats match golden replication, channel packing preserved, out_last on beats 81 and 162.
- Reset asserted after 3 input beats and 5 output beats -> outputs at reset values immediately; new frame 5,6,7,8 -> 5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8.
- SCALE=1, IN_W=4, IN_H=1: inputs 9,8,7,6 -> outputs 9,8,7,6, out_last on 4th.
